vga_sync_ctrl: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/clk_en_div.sv | 35 +++
 rtl/vga_sync_ctrl.sv | 114 +++++++++++
 tb/tb_vga_sync_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 Hz VGA timing constants shared by sync and pixel logic
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_CLK_DIV   = 4;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Counter value and a one-bit-wider position so window ends equal to a total still fit
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   pos_t;

    // Half-open window test lo <= pos < hi
    function automatic logic in_window(pos_t pos, pos_t lo, pos_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - parameterised divider producing a one-cycle enable strobe every DIV clocks
module clk_en_div #(
    parameter int DIV = 4
)(
    input  logic i_clk,
    input  logic i_rst,
    output logic o_en
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_div;
    logic [W-1:0] w_div_next;
    logic         r_en;

    // Next divider value, wrapping at DIV-1
    always_comb begin
        w_div_next = (r_div == LAST) ? '0 : r_div + 1'b1;
    end

    // Strobe is registered so it reads 0 throughout reset even when DIV is 1
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
            r_en  <= 1'b0;
        end else begin
            r_div <= w_div_next;
            r_en  <= (w_div_next == LAST);
        end
    end

    assign o_en = r_en;

endmodule

// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - VGA pixel/line counters, sync decodes and per-frame score shadowing
module vga_sync_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       score0_in,
    input  logic [3:0]       score1_in,
    output logic             pclk_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start,
    output logic [3:0]       score0,
    output logic [3:0]       score1
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam pos_t H_VIS_P  = pos_t'(H_VISIBLE);
    localparam pos_t V_VIS_P  = pos_t'(V_VISIBLE);
    localparam pos_t HS_BEG_P = pos_t'(H_VISIBLE + H_FRONT);
    localparam pos_t HS_END_P = pos_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam pos_t VS_BEG_P = pos_t'(V_VISIBLE + V_FRONT);
    localparam pos_t VS_END_P = pos_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       w_pclk_en;
    logic       w_h_last;
    logic       w_v_last;
    logic       w_frame_wrap;
    pos_t       w_h_pos;
    pos_t       w_v_pos;

    cnt_t       r_h_cnt;
    cnt_t       r_v_cnt;
    logic       r_running;
    logic       r_frame_start;
    logic [3:0] r_score0;
    logic [3:0] r_score1;

    clk_en_div #(
        .DIV (CLK_DIV)
    ) u_pix_div (
        .i_clk (clk),
        .i_rst (rst),
        .o_en  (w_pclk_en)
    );

    assign w_h_last     = (r_h_cnt == H_LAST);
    assign w_v_last     = (r_v_cnt == V_LAST);
    assign w_frame_wrap = w_pclk_en && w_h_last && w_v_last;
    assign w_h_pos      = {1'b0, r_h_cnt};
    assign w_v_pos      = {1'b0, r_v_cnt};

    // Raster position: advance one pixel per strobe, wrapping line then frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pclk_en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Running flag, frame-start pulse and score shadows that only update at the frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_running     <= 1'b0;
            r_frame_start <= 1'b0;
            r_score0      <= '0;
            r_score1      <= '0;
        end else begin
            r_running     <= 1'b1;
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_score0 <= score0_in;
                r_score1 <= score1_in;
            end
        end
    end

    // Decodes come straight off the registered counters so they line up with h_cnt/v_cnt
    assign valid       = r_running && (w_h_pos < H_VIS_P) && (w_v_pos < V_VIS_P);
    assign hsync       = ~(r_running && in_window(w_h_pos, HS_BEG_P, HS_END_P));
    assign vsync       = ~(r_running && in_window(w_v_pos, VS_BEG_P, VS_END_P));

    assign pclk_en     = w_pclk_en;
    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign frame_start = r_frame_start;
    assign score0      = r_score0;
    assign score1      = r_score1;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb/tb_vga_sync_ctrl.sv - scoreboard bench for vga_sync_ctrl at full and reduced timing
module tb_vga_sync_ctrl;

    localparam int T0      = 5;     // cycle index of the last reset edge
    localparam int END_CYC = 3300;

    // Signal ids: instance A base 0, B base 10, C base 20, measured quantities 30+
    localparam int S_PCLK = 0, S_H = 1, S_V = 2, S_VALID = 3, S_HS = 4;
    localparam int S_VS = 5, S_FS = 6, S_S0 = 7, S_S1 = 8;
    localparam int A = 0, B = 10, C = 20;
    localparam int A_HSLOW = 30, B_VSLOW = 31, B_FSCNT = 32, B_FSPER = 33;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [3:0] s0_in, s1_in;

    logic       a_pclk, a_valid, a_hs, a_vs, a_fs;
    logic [9:0] a_h, a_v;
    logic [3:0] a_s0, a_s1;
    logic       b_pclk, b_valid, b_hs, b_vs, b_fs;
    logic [9:0] b_h, b_v;
    logic [3:0] b_s0, b_s1;
    logic       c_pclk, c_valid, c_hs, c_vs, c_fs;
    logic [9:0] c_h, c_v;
    logic [3:0] c_s0, c_s1;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int a_hslow = 0, b_vslow = 0, b_fscnt = 0, b_fsper = 0, b_lastfs = 0;

    typedef struct {
        int    cyc;
        int    sig;
        int    exp;
        string name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_ctrl u_a (
        .clk(clk), .rst(rst_a), .score0_in(s0_in), .score1_in(s1_in),
        .pclk_en(a_pclk), .h_cnt(a_h), .v_cnt(a_v), .valid(a_valid),
        .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .score0(a_s0), .score1(a_s1)
    );

    // Reduced raster: H 8/2/3/2 (15), V 6/1/2/1 (10); hsync h 10..12, vsync v 7..8
    vga_sync_ctrl #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_b (
        .clk(clk), .rst(rst_b), .score0_in(s0_in), .score1_in(s1_in),
        .pclk_en(b_pclk), .h_cnt(b_h), .v_cnt(b_v), .valid(b_valid),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .score0(b_s0), .score1(b_s1)
    );

    vga_sync_ctrl #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_c (
        .clk(clk), .rst(rst_c), .score0_in(s0_in), .score1_in(s1_in),
        .pclk_en(c_pclk), .h_cnt(c_h), .v_cnt(c_v), .valid(c_valid),
        .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs), .score0(c_s0), .score1(c_s1)
    );

    function automatic int sample(int id);
        case (id)
            A + S_PCLK:  return int'(a_pclk);
            A + S_H:     return int'(a_h);
            A + S_V:     return int'(a_v);
            A + S_VALID: return int'(a_valid);
            A + S_HS:    return int'(a_hs);
            A + S_VS:    return int'(a_vs);
            A + S_FS:    return int'(a_fs);
            A + S_S0:    return int'(a_s0);
            A + S_S1:    return int'(a_s1);
            B + S_PCLK:  return int'(b_pclk);
            B + S_H:     return int'(b_h);
            B + S_V:     return int'(b_v);
            B + S_VALID: return int'(b_valid);
            B + S_HS:    return int'(b_hs);
            B + S_VS:    return int'(b_vs);
            B + S_FS:    return int'(b_fs);
            B + S_S0:    return int'(b_s0);
            B + S_S1:    return int'(b_s1);
            C + S_PCLK:  return int'(c_pclk);
            C + S_H:     return int'(c_h);
            C + S_V:     return int'(c_v);
            C + S_VALID: return int'(c_valid);
            C + S_HS:    return int'(c_hs);
            C + S_VS:    return int'(c_vs);
            C + S_FS:    return int'(c_fs);
            C + S_S0:    return int'(c_s0);
            C + S_S1:    return int'(c_s1);
            A_HSLOW:     return a_hslow;
            B_VSLOW:     return b_vslow;
            B_FSCNT:     return b_fscnt;
            B_FSPER:     return b_fsper;
            default:     return -1;
        endcase
    endfunction

    // m is cycles after the last reset edge of the initial reset
    task automatic expect_at(input int m, input int sig, input int exp, input string name);
        exp_t e;
        e.cyc  = T0 + m;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_reset(input int m, input int base, input string tag);
        expect_at(m, base + S_PCLK,  0, {tag, "_rst_pclk"});
        expect_at(m, base + S_H,     0, {tag, "_rst_h"});
        expect_at(m, base + S_V,     0, {tag, "_rst_v"});
        expect_at(m, base + S_VALID, 0, {tag, "_rst_valid"});
        expect_at(m, base + S_HS,    1, {tag, "_rst_hsync"});
        expect_at(m, base + S_VS,    1, {tag, "_rst_vsync"});
        expect_at(m, base + S_FS,    0, {tag, "_rst_fs"});
        expect_at(m, base + S_S0,    0, {tag, "_rst_s0"});
        expect_at(m, base + S_S1,    0, {tag, "_rst_s1"});
    endtask

    task automatic go(input int m);
        while (cyc < T0 + m) @(negedge clk);
    endtask

    // Monitor: update measured quantities, then retire every expectation due this cycle
    initial begin
        int got;
        forever begin
            @(negedge clk);
            if (!a_hs) a_hslow++;
            if (!b_vs) b_vslow++;
            if (b_fs) begin
                b_fscnt++;
                b_fsper  = cyc - b_lastfs;
                b_lastfs = cyc;
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    got = sample(sb[i].sig);
                    checks++;
                    if (got != sb[i].exp) begin
                        failures++;
                        $display("FAIL %s cycle=%0d actual=%0d required=%0d",
                                 sb[i].name, cyc, got, sb[i].exp);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        s0_in = 4'd0; s1_in = 4'd0;

        // Reset phase and first cycles after release
        expect_reset(-2, A, "a");
        expect_reset(-2, B, "b");
        expect_at(-2, C + S_PCLK, 0, "c_rst_pclk");
        expect_reset(0, A, "a0");
        expect_reset(0, C, "c0");
        expect_at(1, A + S_VALID, 1, "a_first_valid");
        expect_at(1, A + S_HS,    1, "a_first_hsync");
        expect_at(1, A + S_VS,    1, "a_first_vsync");
        expect_at(1, A + S_PCLK,  0, "a_pclk_m1");
        expect_at(1, A + S_H,     0, "a_first_h");
        expect_at(2, A + S_PCLK,  0, "a_pclk_m2");
        expect_at(3, A + S_PCLK,  1, "a_pclk_first");
        expect_at(4, A + S_PCLK,  0, "a_pclk_m4");
        expect_at(4, A + S_H,     1, "a_h_step1");
        expect_at(7, A + S_PCLK,  1, "a_pclk_m7");
        expect_at(11, A + S_PCLK, 1, "a_pclk_m11");

        // Full-size line: one sample mid-pixel for every h
        for (int n = 0; n < 800; n++) begin
            expect_at(4 * n + 2, A + S_H, n, "a_line_h");
            expect_at(4 * n + 2, A + S_VALID, (n < 640) ? 1 : 0, "a_line_valid");
            expect_at(4 * n + 2, A + S_HS, (n >= 656 && n < 752) ? 0 : 1, "a_line_hsync");
        end
        expect_at(2559, A + S_VALID, 1, "a_valid_639");
        expect_at(2560, A + S_VALID, 0, "a_valid_640");
        expect_at(2623, A + S_HS, 1, "a_hs_655");
        expect_at(2624, A + S_HS, 0, "a_hs_656");
        expect_at(3007, A + S_HS, 0, "a_hs_751");
        expect_at(3008, A + S_HS, 1, "a_hs_752");
        expect_at(3199, A + S_H, 799, "a_h_799");
        expect_at(3199, A + S_V, 0, "a_v_before_wrap");
        expect_at(3200, A + S_H, 0, "a_h_wrap");
        expect_at(3200, A + S_V, 1, "a_v_step");
        expect_at(3200, A + S_VALID, 1, "a_valid_line1");
        expect_at(3200, A + S_FS, 0, "a_no_fs_line");
        expect_at(3200, A_HSLOW, 384, "a_hsync_low_clk");
        expect_at(3200, A + S_S0, 0, "a_s0_midframe");

        // Reduced raster, CLK_DIV=2
        expect_reset(0, B, "b0");
        expect_at(1, B + S_VALID, 1, "b_first_valid");
        expect_at(1, B + S_PCLK, 1, "b_pclk_m1");
        expect_at(2, B + S_PCLK, 0, "b_pclk_m2");
        expect_at(2, B + S_H, 1, "b_h_step");
        expect_at(15, B + S_VALID, 1, "b_valid_h7");
        expect_at(16, B + S_VALID, 0, "b_valid_h8");
        expect_at(19, B + S_HS, 1, "b_hs_h9");
        expect_at(20, B + S_HS, 0, "b_hs_h10");
        expect_at(25, B + S_HS, 0, "b_hs_h12");
        expect_at(26, B + S_HS, 1, "b_hs_h13");
        expect_at(150, B + S_VALID, 1, "b_valid_v5");
        expect_at(180, B + S_VALID, 0, "b_valid_v6");
        expect_at(208, B + S_VS, 1, "b_vs_v6");
        expect_at(208, B + S_V, 6, "b_v6");
        expect_at(210, B + S_VS, 0, "b_vs_v7");
        expect_at(210, B + S_V, 7, "b_v7");
        expect_at(269, B + S_VS, 0, "b_vs_v8");
        expect_at(270, B + S_VS, 1, "b_vs_v9");
        expect_at(299, B + S_H, 14, "b_h_last");
        expect_at(299, B + S_V, 9, "b_v_last");
        expect_at(299, B + S_FS, 0, "b_fs_pre");
        expect_at(300, B + S_H, 0, "b_frame_h0");
        expect_at(300, B + S_V, 0, "b_frame_v0");
        expect_at(300, B + S_FS, 1, "b_fs_pulse");
        expect_at(300, B_VSLOW, 60, "b_vsync_low_clk");
        expect_at(300, B_FSCNT, 1, "b_fs_count1");
        expect_at(301, B + S_FS, 0, "b_fs_single");

        // Reduced raster, CLK_DIV=1
        expect_at(1, C + S_PCLK, 1, "c_pclk_m1");
        expect_at(1, C + S_H, 0, "c_first_h");
        expect_at(1, C + S_VALID, 1, "c_first_valid");
        expect_at(2, C + S_PCLK, 1, "c_pclk_m2");
        expect_at(2, C + S_H, 1, "c_h_step");
        expect_at(10, C + S_HS, 1, "c_hs_h9");
        expect_at(11, C + S_HS, 0, "c_hs_h10");
        expect_at(13, C + S_HS, 0, "c_hs_h12");
        expect_at(14, C + S_HS, 1, "c_hs_h13");
        expect_at(15, C + S_H, 14, "c_h_last");
        expect_at(16, C + S_H, 0, "c_h_wrap");
        expect_at(16, C + S_V, 1, "c_v_step");
        expect_at(500, C + S_PCLK, 1, "c_pclk_steady");

        go(0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        go(1);
        checks++;
        if (a_valid !== 1'b1) begin
            failures++;
            $display("FAIL direct_a_valid cycle=%0d actual=%0b required=1", cyc, a_valid);
        end
        checks++;
        if (a_hs !== 1'b1) begin
            failures++;
            $display("FAIL direct_a_hsync cycle=%0d actual=%0b required=1", cyc, a_hs);
        end
        checks++;
        if (a_vs !== 1'b1) begin
            failures++;
            $display("FAIL direct_a_vsync cycle=%0d actual=%0b required=1", cyc, a_vs);
        end
        checks++;
        if (c_pclk !== 1'b1) begin
            failures++;
            $display("FAIL direct_c_pclk cycle=%0d actual=%0b required=1", cyc, c_pclk);
        end

        // Scores change mid-frame; shadows follow only at each frame wrap
        go(100);
        s0_in = 4'd5; s1_in = 4'd3;
        expect_at(299, B + S_S0, 0, "b_s0_hold");
        expect_at(299, B + S_S1, 0, "b_s1_hold");
        expect_at(300, B + S_S0, 5, "b_s0_new");
        expect_at(300, B + S_S1, 3, "b_s1_new");
        expect_at(150, C + S_S0, 0, "c_s0_hold");
        expect_at(151, C + S_FS, 1, "c_fs_pulse");
        expect_at(151, C + S_H, 0, "c_frame_h0");
        expect_at(151, C + S_V, 0, "c_frame_v0");
        expect_at(151, C + S_S0, 5, "c_s0_new");
        expect_at(151, C + S_S1, 3, "c_s1_new");
        expect_at(152, C + S_FS, 0, "c_fs_single");
        expect_at(301, C + S_FS, 1, "c_fs_pulse2");
        expect_at(301, C + S_S0, 5, "c_s0_frame2");

        go(400);
        s0_in = 4'd9; s1_in = 4'd7;
        expect_at(450, C + S_S0, 5, "c_s0_hold2");
        expect_at(451, C + S_FS, 1, "c_fs_pulse3");
        expect_at(451, C + S_S0, 9, "c_s0_new2");
        expect_at(451, C + S_S1, 7, "c_s1_new2");
        expect_at(599, B + S_S0, 5, "b_s0_hold2");
        expect_at(599, B + S_S1, 3, "b_s1_hold2");
        expect_at(600, B + S_FS, 1, "b_fs_pulse2");
        expect_at(600, B + S_S0, 9, "b_s0_new2");
        expect_at(600, B + S_S1, 7, "b_s1_new2");
        expect_at(600, B_FSPER, 300, "b_frame_period");

        // One-cycle reset at h=3, v=4 (outside hsync) on the CLK_DIV=2 instance
        go(726);
        rst_b = 1'b1;
        expect_reset(727, B, "b_mid");
        expect_at(727, B_FSCNT, 2, "b_fs_count_rst");
        expect_at(728, B + S_VALID, 1, "b_mid_valid");
        expect_at(728, B + S_H, 0, "b_mid_h");
        expect_at(728, B + S_FS, 0, "b_mid_no_fs");
        expect_at(728, B + S_S0, 0, "b_mid_s0");
        expect_at(800, B + S_H, 6, "b_mid_h6");
        expect_at(800, B + S_V, 2, "b_mid_v2");
        expect_at(1026, B + S_FS, 0, "b_mid_fs_pre");
        expect_at(1026, B_FSCNT, 2, "b_fs_count_pre");
        expect_at(1027, B + S_FS, 1, "b_mid_fs_pulse");
        expect_at(1027, B + S_H, 0, "b_mid_frame_h0");
        expect_at(1027, B + S_V, 0, "b_mid_frame_v0");
        expect_at(1027, B + S_S0, 9, "b_mid_s0_new");
        expect_at(1027, B + S_S1, 7, "b_mid_s1_new");
        go(727);
        rst_b = 1'b0;

        go(END_CYC - T0);
        @(negedge clk);
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s unreached cycle=%0d actual=none required=%0d",
                     sb[i].name, sb[i].cyc, sb[i].exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
